// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search helper for the AXI-Stream arbiter.
// Latency: n/a (types and a purely combinational function).
// Backpressure: n/a.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // First set bit of req at or after ptr, searching upward and wrapping at
    // n_ports, which need not be a power of two. Sized for the largest
    // supported port count (16); callers zero-extend their request vector.
    // Returns ptr when nothing is requesting.
    function automatic logic [3:0] next_rr(
        input logic [15:0] req,
        input logic [3:0]  ptr,
        input int          n_ports
    );
        logic [3:0] sel;
        logic       found;
        logic [4:0] idx;
        sel   = ptr;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < 16; off++) begin
            if (off < n_ports) begin
                idx = 5'(ptr) + 5'(off);
                if (idx >= 5'(n_ports)) begin
                    idx = idx - 5'(n_ports);
                end
                if (!found && req[idx[3:0]]) begin
                    found = 1'b1;
                    sel   = idx[3:0];
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register FIFO that decouples the arbiter from the downstream sink.
// Latency: one cycle from an accepted push to m_valid.
// Backpressure: s_ready is a registered not-full flag, so m_ready never reaches s_ready combinationally.
module axis_skid_buffer
    import axis_arb_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [PAYLOAD_W-1:0] s_payload,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PAYLOAD_W-1:0] m_payload
);

    logic [PAYLOAD_W-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic [1:0]           count_d;
    logic                 full_q;
    logic                 empty_q;
    logic                 push;
    logic                 pop;

    assign s_ready   = ~full_q;
    assign m_valid   = ~empty_q;
    assign m_payload = mem[rd_ptr];

    // While full the slot freed by a pop only becomes writable next cycle.
    assign push = s_valid & ~full_q;
    assign pop  = ~empty_q & m_ready;

    // Occupancy after this cycle; push and pop together leave it unchanged.
    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + 2'd1;
            2'b01:   count_d = count - 2'd1;
            default: count_d = count;
        endcase
    end

    // Storage, pointers and registered full/empty flags; reset zeroes the head.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_payload;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_d;
            full_q  <= (count_d == 2'd2);
            empty_q <= (count_d == 2'd0);
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin mux of N AXI-Stream inputs onto one output, never interleaving packets.
// Latency: grant one cycle after tvalid is seen idle, first beat on m_axis two cycles after; one idle cycle between packets.
// Backpressure: granted s_axis_tready follows the skid buffer's registered not-full; other inputs are held off.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = $clog2(N_PORTS)
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [N_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [N_PORTS-1:0]             s_axis_tvalid,
    output logic [N_PORTS-1:0]             s_axis_tready,
    input  logic [N_PORTS-1:0]             s_axis_tlast,
    input  logic [N_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic [ID_WIDTH-1:0]            m_axis_tid,
    output logic                           busy,
    output logic [ID_WIDTH-1:0]            grant
);

    localparam int PTR_W     = $clog2(N_PORTS);
    localparam int PAYLOAD_W = ID_WIDTH + USER_WIDTH + 1 + DATA_WIDTH;

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_ptr_d;
    logic [PTR_W-1:0]     grant_q;
    logic [PTR_W-1:0]     grant_d;
    logic [PTR_W-1:0]     pick;

    logic [DATA_WIDTH-1:0] sel_tdata;
    logic [USER_WIDTH-1:0] sel_tuser;
    logic                  sel_tlast;
    logic                  sel_tvalid;

    logic                  buf_s_vld;
    logic                  buf_s_rdy;
    logic [PAYLOAD_W-1:0]  buf_s_dat;
    logic [PAYLOAD_W-1:0]  buf_m_dat;

    // Winner of the round-robin search; only consumed while idle.
    assign pick = PTR_W'(next_rr(16'(s_axis_tvalid), 4'(rr_ptr), N_PORTS));

    // Input mux steered by the registered grant.
    assign sel_tdata  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_tuser  = s_axis_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
    assign sel_tlast  = s_axis_tlast[grant_q];
    assign sel_tvalid = s_axis_tvalid[grant_q];

    // Each beat carries the source index so the consumer can tell packets apart.
    assign buf_s_dat = {ID_WIDTH'(grant_q), sel_tuser, sel_tlast, sel_tdata};

    // Arbitration and packet-hold next-state logic; readies are all low unless a packet is in flight.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr;
        grant_d       = grant_q;
        s_axis_tready = '0;
        buf_s_vld     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d  = pick;
                    // Explicit wrap keeps non-power-of-two port counts in range.
                    rr_ptr_d = (pick == PTR_W'(N_PORTS - 1)) ? '0 : pick + 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // A stalled granted source simply waits; nobody else gets in.
                s_axis_tready[grant_q] = buf_s_rdy;
                buf_s_vld              = sel_tvalid;
                if (sel_tvalid && buf_s_rdy && sel_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, round-robin pointer and grant registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr  <= rr_ptr_d;
            grant_q <= grant_d;
        end
    end

    axis_skid_buffer #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .aclk      (aclk),
        .areset    (areset),
        .s_valid   (buf_s_vld),
        .s_ready   (buf_s_rdy),
        .s_payload (buf_s_dat),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready),
        .m_payload (buf_m_dat)
    );

    assign {m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tdata} = buf_m_dat;

    assign busy  = (state_q == BUSY);
    assign grant = ID_WIDTH'(grant_q);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: a 4-port instance plus a 3-port instance for wrap-around.
// Inputs are driven 1-2 ns after the rising edge; outputs and readies are sampled on the falling edge.
// Per-port source queues model AXI-Stream producers; a monitor queue records every output handshake.
module tb_axis_rr_arbiter;

    logic aclk;
    logic areset;
    logic m_ready;
    logic use3;

    logic [3:0]  src_vld = '0;
    logic [31:0] src_dat = '0;
    logic [3:0]  src_lst = '0;
    logic [3:0]  src_usr = '0;
    logic [3:0]  cur_gap = '0;
    logic [3:0]  rdy_s   = '0;
    int          present_cyc [4];
    int          cyc = 0;

    int errors = 0;
    int checks = 0;

    // 4-port instance
    logic [3:0] s4_vld, s4_rdy;
    logic [7:0] m4_dat;
    logic       m4_vld, m4_lst, m4_busy;
    logic [0:0] m4_usr;
    logic [1:0] m4_tid, m4_grant;

    // 3-port instance
    logic [2:0] s3_vld, s3_rdy;
    logic [7:0] m3_dat;
    logic       m3_vld, m3_lst, m3_busy;
    logic [0:0] m3_usr;
    logic [1:0] m3_tid, m3_grant;

    assign s4_vld = use3 ? 4'b0 : src_vld;
    assign s3_vld = use3 ? src_vld[2:0] : 3'b0;

    axis_rr_arbiter #(.N_PORTS(4), .DATA_WIDTH(8), .USER_WIDTH(1)) dut4 (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(src_dat), .s_axis_tvalid(s4_vld), .s_axis_tready(s4_rdy),
        .s_axis_tlast(src_lst), .s_axis_tuser(src_usr),
        .m_axis_tdata(m4_dat), .m_axis_tvalid(m4_vld), .m_axis_tready(m_ready),
        .m_axis_tlast(m4_lst), .m_axis_tuser(m4_usr), .m_axis_tid(m4_tid),
        .busy(m4_busy), .grant(m4_grant)
    );

    axis_rr_arbiter #(.N_PORTS(3), .DATA_WIDTH(8), .USER_WIDTH(1)) dut3 (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(src_dat[23:0]), .s_axis_tvalid(s3_vld), .s_axis_tready(s3_rdy),
        .s_axis_tlast(src_lst[2:0]), .s_axis_tuser(src_usr[2:0]),
        .m_axis_tdata(m3_dat), .m_axis_tvalid(m3_vld), .m_axis_tready(m_ready),
        .m_axis_tlast(m3_lst), .m_axis_tuser(m3_usr), .m_axis_tid(m3_tid),
        .busy(m3_busy), .grant(m3_grant)
    );

    logic [7:0] mo_dat;
    logic       mo_vld, mo_lst, mo_usr, mo_busy;
    logic [1:0] mo_tid, mo_grant;
    logic [3:0] mo_srdy;

    assign mo_dat   = use3 ? m3_dat   : m4_dat;
    assign mo_vld   = use3 ? m3_vld   : m4_vld;
    assign mo_lst   = use3 ? m3_lst   : m4_lst;
    assign mo_usr   = use3 ? m3_usr[0] : m4_usr[0];
    assign mo_tid   = use3 ? m3_tid   : m4_tid;
    assign mo_busy  = use3 ? m3_busy  : m4_busy;
    assign mo_grant = use3 ? m3_grant : m4_grant;
    assign mo_srdy  = use3 ? {1'b0, s3_rdy} : s4_rdy;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct packed {
        logic       gap;
        logic [7:0] d;
        logic       l;
        logic       u;
    } sbeat_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
        logic [1:0] id;
        int         cyc;
    } obeat_t;

    sbeat_t sq [4][$];
    obeat_t oq [$];

    // Ready seen mid-cycle equals ready at the next edge (it depends on DUT registers only).
    always @(negedge aclk) rdy_s = mo_srdy;

    // Output monitor: one entry per handshake.
    always @(negedge aclk) begin
        obeat_t ob;
        if (!areset && mo_vld && m_ready) begin
            ob.d   = mo_dat;
            ob.l   = mo_lst;
            ob.u   = mo_usr;
            ob.id  = mo_tid;
            ob.cyc = cyc;
            oq.push_back(ob);
        end
    end

    // Source model: retire the accepted beat or elapsed gap, then present the next entry.
    always @(posedge aclk) begin
        #1;
        for (int p = 0; p < 4; p++) begin
            if ((src_vld[p] && rdy_s[p]) || cur_gap[p]) begin
                if (sq[p].size() > 0) sq[p].delete(0);
            end
            cur_gap[p] = 1'b0;
            if (sq[p].size() > 0 && sq[p][0].gap) begin
                src_vld[p] = 1'b0;
                cur_gap[p] = 1'b1;
            end else if (sq[p].size() > 0) begin
                if (!src_vld[p]) present_cyc[p] = cyc;
                src_vld[p]          = 1'b1;
                src_dat[p*8 +: 8]   = sq[p][0].d;
                src_lst[p]          = sq[p][0].l;
                src_usr[p]          = sq[p][0].u;
            end else begin
                src_vld[p] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_beat(input int p, input logic [7:0] d, input logic l, input logic u, input logic gap);
        sbeat_t b;
        b.gap = gap;
        b.d   = d;
        b.l   = l;
        b.u   = u;
        sq[p].push_back(b);
    endtask

    task automatic load_pkt(input int p, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            push_beat(p, base + 8'(i), (i == len - 1), 1'b0, 1'b0);
        end
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int k = 0;
        while (oq.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, oq.size(), n);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        for (int p = 0; p < 4; p++) sq[p].delete();
        src_vld = '0;
        cur_gap = '0;
        idle(2);
        areset = 1'b0;
        oq.delete();
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        areset  = 1'b1;
        m_ready = 1'b1;
        use3    = 1'b0;

        // Reset state
        @(negedge aclk);
        check("rst_m_tvalid", mo_vld, 0);
        check("rst_busy", mo_busy, 0);
        check("rst_grant", mo_grant, 0);
        check("rst_s_tready", mo_srdy, 0);
        check("rst_m_tdata", mo_dat, 0);
        check("rst_m_tid", mo_tid, 0);
        check("rst_rr_ptr", 32'(dut4.rr_ptr), 0);
        tick();
        areset = 1'b0;
        idle(2);

        // Single source: port 2 sends AA,BB,CC
        push_beat(2, 8'hAA, 1'b0, 1'b0, 1'b0);
        push_beat(2, 8'hBB, 1'b0, 1'b1, 1'b0);
        push_beat(2, 8'hCC, 1'b1, 1'b0, 1'b0);
        wait_out(3, 20, "single_cnt");
        if (oq.size() == 3) begin
            check("single_d0", oq[0].d, 8'hAA);
            check("single_d1", oq[1].d, 8'hBB);
            check("single_d2", oq[2].d, 8'hCC);
            check("single_u1", oq[1].u, 1);
            check("single_last0", oq[0].l, 0);
            check("single_last2", oq[2].l, 1);
            for (int i = 0; i < 3; i++) check($sformatf("single_tid%0d", i), oq[i].id, 2);
            check("single_latency", oq[0].cyc - present_cyc[2], 2);
            check("single_b2b", oq[2].cyc - oq[0].cyc, 2);
        end
        check("single_rr_ptr", 32'(dut4.rr_ptr), 3);
        idle(3);

        // Fairness: every port queues two 2-beat packets
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) load_pkt(p, 2, 8'(p * 16 + k * 2));
        wait_out(16, 200, "fair_cnt");
        if (oq.size() == 16) begin
            for (int j = 0; j < 8; j++) begin
                check($sformatf("fair_tid_pkt%0d", j), oq[2*j].id, j % 4);
                check($sformatf("fair_d_pkt%0d_b0", j), oq[2*j].d, (j % 4) * 16 + (j / 4) * 2);
                check($sformatf("fair_d_pkt%0d_b1", j), oq[2*j+1].d, (j % 4) * 16 + (j / 4) * 2 + 1);
                check($sformatf("fair_last_pkt%0d", j), {oq[2*j].l, oq[2*j+1].l}, 2'b01);
                if (j > 0) check($sformatf("fair_gap_pkt%0d", j), oq[2*j].cyc - oq[2*j-2].cyc, 3);
            end
        end
        idle(4);
        oq.delete();

        // No interleave: port 0 stalls 3 cycles mid-packet while port 1 requests
        push_beat(0, 8'h00, 1'b0, 1'b0, 1'b0);
        push_beat(0, 8'h01, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) push_beat(0, 8'h00, 1'b0, 1'b0, 1'b1);
        push_beat(0, 8'h02, 1'b0, 1'b0, 1'b0);
        push_beat(0, 8'h03, 1'b1, 1'b0, 1'b0);
        load_pkt(1, 2, 8'h10);
        wait_out(6, 60, "nointl_cnt");
        if (oq.size() == 6) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("nointl_tid%0d", i), oq[i].id, 0);
                check($sformatf("nointl_d%0d", i), oq[i].d, i);
            end
            check("nointl_tid4", oq[4].id, 1);
            check("nointl_d5", oq[5].d, 8'h11);
        end
        idle(4);
        oq.delete();

        // Backpressure: sink stalled while port 0 sends 6 beats
        m_ready = 1'b0;
        load_pkt(0, 6, 8'h60);
        idle(5);
        @(negedge aclk);
        check("bp_s_tready", mo_srdy[0], 0);
        check("bp_m_tvalid", mo_vld, 1);
        check("bp_absorbed", 6 - sq[0].size(), 2);
        check("bp_head", mo_dat, 8'h60);
        tick();
        @(negedge aclk);
        check("bp_head_stable", mo_dat, 8'h60);
        check("bp_absorbed_stable", 6 - sq[0].size(), 2);
        tick();
        m_ready = 1'b1;
        wait_out(6, 40, "bp_cnt");
        if (oq.size() == 6)
            for (int i = 0; i < 6; i++) check($sformatf("bp_d%0d", i), oq[i].d, 8'h60 + i);
        idle(5);
        check("bp_no_dup", oq.size(), 6);
        oq.delete();

        // Reset mid-packet: port 1 sends 5 beats, reset after two have left
        load_pkt(1, 5, 8'h70);
        wait_out(2, 30, "rstmid_pre_cnt");
        areset = 1'b1;
        #1;
        check("rstmid_m_tvalid", mo_vld, 0);
        check("rstmid_m_tdata", mo_dat, 0);
        check("rstmid_m_tlast", mo_lst, 0);
        check("rstmid_m_tuser", mo_usr, 0);
        check("rstmid_m_tid", mo_tid, 0);
        check("rstmid_busy", mo_busy, 0);
        check("rstmid_grant", mo_grant, 0);
        check("rstmid_s_tready", mo_srdy, 0);
        check("rstmid_rr_ptr", 32'(dut4.rr_ptr), 0);
        sq[1].delete();
        src_vld = '0;
        cur_gap = '0;
        idle(2);
        areset = 1'b0;
        oq.delete();
        idle(4);
        check("rstmid_dropped", oq.size(), 0);
        load_pkt(3, 3, 8'h30);
        wait_out(3, 30, "rstmid_p3_cnt");
        if (oq.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rstmid_p3_tid%0d", i), oq[i].id, 3);
                check($sformatf("rstmid_p3_d%0d", i), oq[i].d, 8'h30 + i);
            end
            check("rstmid_p3_last", oq[2].l, 1);
        end
        check("rstmid_rr_after", 32'(dut4.rr_ptr), 0);
        idle(4);
        oq.delete();

        // Wrap-around on the 3-port instance: port 2, then ports 0 and 1 together
        use3 = 1'b1;
        push_beat(2, 8'h2A, 1'b1, 1'b0, 1'b0);
        wait_out(1, 20, "wrap_p2_cnt");
        if (oq.size() == 1) check("wrap_p2_tid", oq[0].id, 2);
        check("wrap_rr_ptr", 32'(dut3.rr_ptr), 0);
        idle(3);
        push_beat(0, 8'h0A, 1'b1, 1'b0, 1'b0);
        push_beat(1, 8'h1A, 1'b1, 1'b0, 1'b0);
        wait_out(3, 30, "wrap_cnt");
        if (oq.size() == 3) begin
            check("wrap_tid_first", oq[1].id, 0);
            check("wrap_d_first", oq[1].d, 8'h0A);
            check("wrap_tid_second", oq[2].id, 1);
            check("wrap_d_second", oq[2].d, 8'h1A);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream master output among N AXI-Stream slave inputs. It sits in front of a single downstream `axis_if` consumer, such as a DMA or serializer, and lets several producers use it. Once a packet is granted, its beats are never interleaved with another input's beats. The output is registered through a 2-entry skid buffer, so `m_axis_tready` has no combinational path to any `s_axis_tready`.

## Interface
- Clock `aclk`; reset `areset` is asynchronous and active-high.
- `N_PORTS`, default 4: number of slave inputs, range 2..16.
- `DATA_WIDTH`, default 8: tdata width per port.
- `USER_WIDTH`, default 1: tuser width per port.
- `ID_WIDTH`, default `$clog2(N_PORTS)`: width of `m_axis_tid`.
- `aclk`  in  1  clock.
- `areset`  in  1  asynchronous active-high reset.
- `s_axis_tdata`  in  N_PORTS*DATA_WIDTH  port i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid`  in  N_PORTS  per-port valid.
- `s_axis_tready`  out  N_PORTS  per-port ready.
- `s_axis_tlast`  in  N_PORTS  per-port end of packet.
- `s_axis_tuser`  in  N_PORTS*USER_WIDTH  per-port user sideband.
- `m_axis_tdata`  out  DATA_WIDTH  output data.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  output end of packet.
- `m_axis_tuser`  out  USER_WIDTH  output user sideband.
- `m_axis_tid`  out  ID_WIDTH  index of the source port for this beat.
- `busy`  out  1  high while a packet is granted.
- `grant`  out  ID_WIDTH  index of the currently granted port; valid while `busy` is high.

## Operation
- The FSM has two states, `IDLE` and `BUSY`. The registers are `rr_ptr` and `grant`.
- **IDLE:**
  - If any `s_axis_tvalid` bit is set, select the first valid port at or after `rr_ptr`, searching upward modulo N_PORTS.
  - Register that index as `grant`, set `rr_ptr <= (grant+1) mod N_PORTS`, and go to `BUSY`.
  - All `s_axis_tready` bits are 0 in `IDLE`.
- **BUSY:**
  - `s_axis_tready[grant] = ~buf_full`; every other bit is 0.
  - Each accepted beat is pushed into the skid buffer with `tid = grant`.
  - An accepted beat with `tlast=1` moves the FSM to `IDLE` on the next edge.
- **Wrap-around:** the modulo wrap of `rr_ptr` must also be correct when N_PORTS is not a power of 2. Example: with N=3 and grant=2, `rr_ptr` becomes 0.
- **Grant hold:** the grant is held for the whole packet.
  - If the granted source drops `tvalid` mid-packet, the arbiter waits; other requesters are ignored.
  - A single-beat packet (tlast on beat 0) returns to `IDLE` after one beat.
- **Skid buffer:**
  - 2-entry FIFO. `buf_full` is registered.
  - Output fields come from the buffer head; `m_axis_tvalid = ~buf_empty`.
  - A push and a pop in the same cycle keep the occupancy unchanged.
  - A pop while full frees a slot on the next cycle.
- **Fairness:** a continuously requesting port waits at most N_PORTS-1 packets before it is granted.

## Timing
- **Reset:** `areset` acts immediately, asynchronously. It sets:
  - FSM = `IDLE`, `rr_ptr` = 0, `grant` = 0, `busy` = 0.
  - Buffer emptied, so `m_axis_tvalid` = 0.
  - `m_axis_tdata`/`tlast`/`tuser`/`tid` = 0.
  - `s_axis_tready` = 0.
- **Reset mid-packet:** the partial packet is dropped; nothing is emitted for it after reset is released. The first arbitration after release starts at port 0.
- **Latency:** tvalid is first seen in `IDLE` at cycle 0.
  - Grant is registered at edge 1.
  - `s_axis_tready` is high during cycle 1 and beat 0 is accepted at edge 2.
  - `m_axis_tvalid` goes high in cycle 2.
- **Throughput:**
  - 1 beat/cycle within a packet while `m_axis_tready`=1.
  - 1 bubble cycle (the `IDLE` cycle) between consecutive packets.
- **Backpressure:** with `m_axis_tready`=0, the buffer absorbs 2 beats, then `s_axis_tready` drops. No beat is lost or duplicated.
- `m_axis_*` outputs hold stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.

## Structure
- Package `axis_arb_pkg`:
  - `typedef enum logic {IDLE, BUSY} arb_state_t`.
  - A `next_rr` function that computes the round-robin search from the request vector and `rr_ptr`.
- Sub-module `axis_skid_buffer`:
  - Parameterized on payload width.
  - Payload is `{tid, tuser, tlast, tdata}`.
  - Ports: `s_valid`, `s_ready`, `m_valid`, `m_ready`.
- The top level holds the FSM, the arbitration logic and the input mux.

## Test plan
- **Single source:** port 2 sends a 3-beat packet AA,BB,CC with `m_tready`=1.
  - Output is AA,BB,CC with tid=2 and tlast on CC.
  - First output beat appears 2 cycles after tvalid.
  - Afterwards `rr_ptr`=3.
- **Fairness:** N=4, all ports continuously send 2-beat packets.
  - Grant order is 0,1,2,3,0.
  - Never two packets from one port back-to-back while others wait.
  - Exactly one idle cycle between packets.
- **No interleave:** port 0 sends 4 beats and drops tvalid for 3 cycles after beat 1, while port 1 requests.
  - All 4 beats from port 0 come out before any port-1 beat.
- **Backpressure:** `m_tready` held 0 for 5 cycles during a 6-beat packet.
  - Exactly 2 beats are buffered, `s_tready` goes 0, and on release all 6 beats arrive in order with no duplicates.
- **Reset mid-packet:** `areset` pulsed after beat 2 of 5.
  - All outputs go to their reset values in that cycle.
  - The next packet from port 3 is granted from `rr_ptr`=0 and emitted intact.
- **Wrap-around:** N=3, single-beat packets from port 2 then port 0.
  - `rr_ptr` wraps 2→0 and both packets are granted in order.
